// File: rtl/rf_cmd_pkg.sv
// Shared constants for the register-file command master.
// Command bytes, the read-error reply byte and the FSM state encoding.
package rf_cmd_pkg;

   localparam logic [7:0] CMD_WR   = 8'hAA;
   localparam logic [7:0] CMD_RD   = 8'hBB;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_ADDR = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_WAIT = 3'd4;
   localparam logic [2:0] ST_TX_SEND = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      WR_ADDR = ST_WR_ADDR,
      WR_DATA = ST_WR_DATA,
      RD_ADDR = ST_RD_ADDR,
      RD_WAIT = ST_RD_WAIT,
      TX_SEND = ST_TX_SEND
   } state_t;

endpackage

// File: rtl/rf_cmd_timer.sv
// Saturating timeout counter shared by the inter-byte and read-response waits.
// Ports: CLK, RST (async active-low), clr_i, en_i in; expired_o out (count == TO_CYCLES).
module rf_cmd_timer #(
   parameter int TO_CYCLES = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int TW = $clog2(TO_CYCLES + 1);
   localparam logic [TW-1:0] LIM = TW'(TO_CYCLES);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != LIM))
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LIM);

endmodule

// File: rtl/rf_cmd_master.sv
// Decodes UART command frames into register-file write/read strobes and returns read data.
// Ports: CLK, RST, RX_P_DATA/RX_D_VLD, RdData/RdData_VLD, TX_BUSY in;
//        WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY out (all registered).
module rf_cmd_master
   import rf_cmd_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int ADDR      = 4,
   parameter int TO_CYCLES = 255
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] RX_P_DATA,
   input  logic             RX_D_VLD,
   input  logic [WIDTH-1:0] RdData,
   input  logic             RdData_VLD,
   input  logic             TX_BUSY,
   output logic             WrEn,
   output logic             RdEn,
   output logic [ADDR-1:0]  Address,
   output logic [WIDTH-1:0] WrData,
   output logic [WIDTH-1:0] TX_P_DATA,
   output logic             TX_D_VLD,
   output logic             CMD_ERR,
   output logic             BUSY
);

   localparam logic [WIDTH-1:0] C_WR  = WIDTH'(CMD_WR);
   localparam logic [WIDTH-1:0] C_RD  = WIDTH'(CMD_RD);
   localparam logic [WIDTH-1:0] C_ERR = WIDTH'(ERR_BYTE);

   state_t           state_q, state_d;
   logic             wren_q, wren_d;
   logic             rden_q, rden_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] txd_q, txd_d;
   logic             txv_q, txv_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic tmr_clr, tmr_en, tmr_exp, gap_st;

   rf_cmd_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
      .CLK       (CLK),
      .RST       (RST),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_exp)
   );

   assign gap_st = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                   (state_q == RD_ADDR);

   always_comb begin
      state_d = state_q;
      wren_d  = 1'b0;
      rden_d  = 1'b0;
      err_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      txd_d   = txd_q;
      txv_d   = txv_q;

      unique case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == C_WR)
                  state_d = WR_ADDR;
               else if (RX_P_DATA == C_RD)
                  state_d = RD_ADDR;
               else
                  err_d = 1'b1;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR-1:0];
               state_d = WR_DATA;
            end else if (tmr_exp) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wdata_d = RX_P_DATA;
               wren_d  = 1'b1;
               state_d = IDLE;
            end else if (tmr_exp) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR-1:0];
               rden_d  = 1'b1;
               state_d = RD_WAIT;
            end else if (tmr_exp) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (RX_D_VLD)
               err_d = 1'b1;
            if (RdData_VLD) begin
               txd_d   = RdData;
               state_d = TX_SEND;
            end else if (tmr_exp) begin
               txd_d   = C_ERR;
               err_d   = 1'b1;
               state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (RX_D_VLD)
               err_d = 1'b1;
            // Raise only into an idle TX; once raised, drop on the
            // first cycle the TX reports busy (byte accepted).
            if (!txv_q) begin
               if (!TX_BUSY)
                  txv_d = 1'b1;
            end else if (TX_BUSY) begin
               txv_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      tmr_en  = gap_st || (state_q == RD_WAIT);
      tmr_clr = (state_d != state_q) || (RX_D_VLD && gap_st);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         wren_q  <= 1'b0;
         rden_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wren_q  <= wren_d;
         rden_q  <= rden_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign WrEn      = wren_q;
   assign RdEn      = rden_q;
   assign Address   = addr_q;
   assign WrData    = wdata_q;
   assign TX_P_DATA = txd_q;
   assign TX_D_VLD  = txv_q;
   assign CMD_ERR   = err_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_rf_cmd_master.sv
// Directed self-checking bench for rf_cmd_master.
// Drives UART-side bytes, models the register file and TX handshake.
module tb_rf_cmd_master;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic [7:0] RdData;
   logic       RdData_VLD;
   logic       TX_BUSY;
   logic       WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY;
   logic [3:0] Address;
   logic [7:0] WrData, TX_P_DATA;

   int errors = 0;
   int checks = 0;

   logic       rf_respond;
   logic [7:0] rf_val;

   int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, tx_starts = 0;
   logic tx_prev = 1'b0;

   always #5 CLK = ~CLK;

   rf_cmd_master dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .RdData_VLD(RdData_VLD),
      .TX_BUSY(TX_BUSY),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .CMD_ERR(CMD_ERR), .BUSY(BUSY)
   );

   // Register-file model: data valid one cycle after RdEn.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RdData_VLD <= 1'b0;
         RdData     <= 8'h00;
      end else begin
         RdData_VLD <= RdEn && rf_respond;
         RdData     <= rf_val;
      end
   end

   always @(posedge CLK) begin
      if (WrEn) wr_cnt++;
      if (RdEn) rd_cnt++;
      if (WrEn && RdEn) both_cnt++;
      if (TX_D_VLD && !tx_prev) tx_starts++;
      tx_prev = TX_D_VLD;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
   endtask

   // Waits for TX_D_VLD, checks the byte, then completes the handshake.
   task automatic tx_handshake(input logic [7:0] exp, input string nm);
      int n;
      bit seen;
      seen = 0;
      for (n = 0; n < 400; n++) begin
         if (TX_D_VLD) begin seen = 1; break; end
         @(negedge CLK);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_txvld: TX_D_VLD never rose, required 1", nm);
      end
      checks++;
      if (TX_P_DATA !== exp) begin
         errors++;
         $display("FAIL %s_txdata: got %h required %h", nm, TX_P_DATA, exp);
      end
      @(negedge CLK);
      checks++;
      if (TX_D_VLD !== 1'b1) begin
         errors++;
         $display("FAIL %s_txhold: TX_D_VLD=%b required 1", nm, TX_D_VLD);
      end
      TX_BUSY = 1'b1;
      @(negedge CLK);
      checks++;
      if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL %s_txdone: TX_D_VLD=%b BUSY=%b required 0 0",
                  nm, TX_D_VLD, BUSY);
      end
      TX_BUSY = 1'b0;
   endtask

   // Counts cycles until CMD_ERR pulses; returns 999 if it never does.
   task automatic wait_err(output int cyc);
      cyc = 999;
      for (int n = 1; n <= 400; n++) begin
         @(negedge CLK);
         if (CMD_ERR) begin cyc = n; break; end
      end
   endtask

   task automatic test_reset;
      RST = 1'b0;
      RX_P_DATA = 8'h00;
      RX_D_VLD = 1'b0;
      TX_BUSY = 1'b0;
      rf_respond = 1'b1;
      rf_val = 8'h00;
      repeat (3) @(negedge CLK);
      checks++;
      if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY}
          !== '0) begin
         errors++;
         $display("FAIL reset: outputs %b %b %h %h %h %b %b %b required all 0",
                  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD,
                  CMD_ERR, BUSY);
      end
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_write;
      int w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h5C);
      checks++;
      if (WrEn !== 1'b1 || Address !== 4'h3 || WrData !== 8'h5C) begin
         errors++;
         $display("FAIL write_strobe: WrEn=%b Addr=%h Data=%h required 1 3 5c",
                  WrEn, Address, WrData);
      end
      @(negedge CLK);
      checks++;
      if (WrEn !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL write_end: WrEn=%b BUSY=%b required 0 0", WrEn, BUSY);
      end
      checks++;
      if (wr_cnt - w0 != 1 || rd_cnt - r0 != 0) begin
         errors++;
         $display("FAIL write_counts: wr=%0d rd=%0d required 1 0",
                  wr_cnt - w0, rd_cnt - r0);
      end
   endtask

   task automatic test_read;
      int w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      rf_respond = 1'b1;
      rf_val = 8'h21;
      send_byte(8'hBB);
      send_byte(8'h02);
      checks++;
      if (RdEn !== 1'b1 || Address !== 4'h2 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL read_strobe: RdEn=%b Addr=%h BUSY=%b required 1 2 1",
                  RdEn, Address, BUSY);
      end
      tx_handshake(8'h21, "read");
      checks++;
      if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
         errors++;
         $display("FAIL read_counts: rd=%0d wr=%0d required 1 0",
                  rd_cnt - r0, wr_cnt - w0);
      end
   endtask

   task automatic test_read_timeout;
      int cyc;
      rf_respond = 1'b0;
      send_byte(8'hBB);
      send_byte(8'h01);
      wait_err(cyc);
      checks++;
      if (cyc < 255 || cyc > 257) begin
         errors++;
         $display("FAIL rd_timeout_cyc: CMD_ERR after %0d cycles required 255..257",
                  cyc);
      end
      checks++;
      if (TX_P_DATA !== 8'hEE) begin
         errors++;
         $display("FAIL rd_timeout_byte: got %h required ee", TX_P_DATA);
      end
      tx_handshake(8'hEE, "rd_timeout");
      rf_respond = 1'b1;
   endtask

   task automatic test_bad_cmd;
      int w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      send_byte(8'h12);
      checks++;
      if (CMD_ERR !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL bad_cmd: CMD_ERR=%b BUSY=%b required 1 0", CMD_ERR, BUSY);
      end
      @(negedge CLK);
      checks++;
      if (CMD_ERR !== 1'b0 || wr_cnt != w0 || rd_cnt != r0) begin
         errors++;
         $display("FAIL bad_cmd_pulse: CMD_ERR=%b strobes=%0d required 0 0",
                  CMD_ERR, (wr_cnt - w0) + (rd_cnt - r0));
      end
   endtask

   task automatic test_gap_timeout;
      int cyc, w0;
      w0 = wr_cnt;
      send_byte(8'hAA);
      wait_err(cyc);
      checks++;
      if (cyc < 255 || cyc > 257 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL gap_timeout: after %0d cycles BUSY=%b required 255..257 0",
                  cyc, BUSY);
      end
      checks++;
      if (wr_cnt != w0) begin
         errors++;
         $display("FAIL gap_nowr: WrEn pulses %0d required 0", wr_cnt - w0);
      end
      rf_val = 8'h77;
      send_byte(8'hBB);
      send_byte(8'hFC);
      checks++;
      if (RdEn !== 1'b1 || Address !== 4'hC) begin
         errors++;
         $display("FAIL gap_next_read: RdEn=%b Addr=%h required 1 c", RdEn, Address);
      end
      tx_handshake(8'h77, "gap_next");
   endtask

   task automatic test_backpressure;
      int bad, t0;
      bad = 0;
      rf_val = 8'h21;
      TX_BUSY = 1'b1;
      t0 = tx_starts;
      send_byte(8'hBB);
      send_byte(8'h05);
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 20; i++) begin
         if (TX_D_VLD !== 1'b0) bad++;
         @(negedge CLK);
      end
      checks++;
      if (bad != 0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: TX_D_VLD high %0d cycles BUSY=%b required 0 1",
                  bad, BUSY);
      end
      TX_BUSY = 1'b0;
      tx_handshake(8'h21, "bp");
      repeat (3) @(negedge CLK);
      checks++;
      if (tx_starts - t0 != 1) begin
         errors++;
         $display("FAIL bp_once: TX starts %0d required 1", tx_starts - t0);
      end
   endtask

   task automatic test_reset_mid;
      int w0;
      send_byte(8'hAA);
      send_byte(8'h03);
      checks++;
      if (BUSY !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: BUSY=%b required 1", BUSY);
      end
      RST = 1'b0;
      #1;
      checks++;
      if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY}
          !== '0) begin
         errors++;
         $display("FAIL mid_reset: outputs not all 0 (Addr=%h WrData=%h BUSY=%b)",
                  Address, WrData, BUSY);
      end
      @(negedge CLK);
      RST = 1'b1;
      w0 = wr_cnt;
      send_byte(8'h5C);
      checks++;
      if (CMD_ERR !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: CMD_ERR=%b BUSY=%b required 1 0", CMD_ERR, BUSY);
      end
      repeat (2) @(negedge CLK);
      checks++;
      if (wr_cnt != w0) begin
         errors++;
         $display("FAIL mid_nowr: WrEn pulses %0d required 0", wr_cnt - w0);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_timeout();
      test_bad_cmd();
      test_gap_timeout();
      test_backpressure();
      test_reset_mid();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL strobe_overlap: WrEn&RdEn cycles %0d required 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
